alu_mul_seq: RTL
================

ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-004 SHALL have port a, input, 16 bits: multiplicand.
REQ-005 SHALL have port b, input, 16 bits: multiplier.
REQ-006 SHALL have port busy, output, 1 bit: high in ADD and DBL states.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse in DONE state.
REQ-008 SHALL have port product, output, 16 bits: low 16 bits of a*b; held until the next accepted start.
REQ-009 SHALL have ports product_zr and product_ng, outputs, 1 bit each: product==0; product[15].
REQ-010 SHALL have ports alu_x and alu_y, outputs, 16 bits each: operands to the shared Hack ALU.
REQ-011 SHALL have ports alu_zx, alu_nx, alu_zy, alu_ny, alu_f and alu_no, outputs, 1 bit each: ALU control bits.
REQ-012 SHALL have port alu_out, input, 16 bits: combinational ALU result for the operands and controls driven in the same cycle.

Function
REQ-013 SHALL hold internal registers acc, mc and mp (16 bits each) and a state register with states IDLE, ADD, DBL and DONE.
REQ-014 In IDLE with start=1, SHALL load acc=0, mc=a, mp=b and go to ADD; start in any other state SHALL be ignored.
REQ-015 ADD with mp[0]=1 SHALL drive alu_x=acc, alu_y=mc and controls zx,nx,zy,ny,f,no=000010 (x+y).
REQ-016 ADD with mp[0]=0 SHALL drive alu_x=acc, alu_y=mc and controls 001100 (x&0xFFFF, pass x).
REQ-017 ADD SHALL latch acc<=alu_out, then go to DONE if mp[15:1]==0, else to DBL.
REQ-018 DBL SHALL drive alu_x=mc, alu_y=mc and controls 000010, latch mc<=alu_out (mc doubled, modulo 2^16), set mp<=mp>>1 (zero fill) and go to ADD.
REQ-019 DONE SHALL assert done=1, set product<=acc, set product_zr and product_ng from that acc, and go to IDLE.
REQ-020 In IDLE and DONE, the block SHALL drive alu_x=0, alu_y=0 and controls 101010 (constant 0).
REQ-021 Arithmetic SHALL be modulo 2^16; overflow SHALL be discarded silently.
REQ-022 Latency: start sampled at cycle 0 SHALL give done at cycle 2k+2, where k is the index of the highest set bit of b (k=0 when b=0); the maximum is cycle 32.
REQ-023 done SHALL be high for exactly one cycle per accepted start; busy and done SHALL never be high in the same cycle.
REQ-024 start held high through DONE SHALL be accepted on the first IDLE cycle after DONE, not in the DONE cycle itself.

Reset
REQ-025 reset=1 at a clock edge SHALL force: state IDLE, acc=mc=mp=0, busy=0, done=0, product=0x0000, product_zr=1, product_ng=0.
REQ-026 reset SHALL take priority over start and over any in-progress operation.
REQ-027 After a reset mid-operation, no done pulse for the aborted operation SHALL be produced.

Verification
REQ-028 a=3, b=5, start at cycle 0 -> done at cycle 6; product=0x000F, zr=0, ng=0.
REQ-029 a=0x1234, b=0 -> done at cycle 2; product=0x0000, zr=1; alu_out is never latched as a nonzero value.
REQ-030 a=0xFFFF, b=0xFFFF -> done at cycle 32; product=0x0001. Separately, a=0x0100, b=0x0100 -> product=0x0000, zr=1.
REQ-031 a=0x8000, b=1 -> done at cycle 2; product=0x8000, ng=1, zr=0.
REQ-032 a=3, b=5 started, then start pulsed with a=7, b=7 at cycle 3 -> done at cycle 6 with product 0x000F and no second done pulse.
REQ-033 a=3, b=0x8000 started, reset asserted at cycle 10 -> no done pulse; outputs at reset values; a new start then completes normally.
REQ-034 All scenarios SHALL check every cycle's ALU controls against REQ-015, REQ-016, REQ-018 and REQ-020, with the bench modelling the combinational ALU.

Source files
------------

// File: rtl/alu_mul_seq.sv
// Sequential 16x16 -> 16 shift-and-add multiplier that borrows an external
// Hack ALU for every addition, pass-through and doubling step.
module alu_mul_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        product_zr,
  output logic        product_ng,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [15:0] alu_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DBL  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // ALU control words, ordered zx,nx,zy,ny,f,no
  localparam logic [5:0] CtlAdd  = 6'b000010;  // x + y
  localparam logic [5:0] CtlPass = 6'b001100;  // x & 0xFFFF
  localparam logic [5:0] CtlZero = 6'b101010;  // constant 0

  logic [1:0]  state_q;
  logic [15:0] acc_q;
  logic [15:0] mc_q;
  logic [15:0] mp_q;
  logic [15:0] product_q;
  logic        zr_q;
  logic        ng_q;
  logic [5:0]  ctl;

  assign busy       = (state_q == ADD) || (state_q == DBL);
  assign done       = (state_q == DONE);
  assign product    = product_q;
  assign product_zr = zr_q;
  assign product_ng = ng_q;

  assign alu_zx = ctl[5];
  assign alu_nx = ctl[4];
  assign alu_zy = ctl[3];
  assign alu_ny = ctl[2];
  assign alu_f  = ctl[1];
  assign alu_no = ctl[0];

  // ALU operand and control selection for the current state
  always_comb begin
    alu_x = 16'h0000;
    alu_y = 16'h0000;
    ctl   = CtlZero;
    case (state_q)
      ADD: begin
        alu_x = acc_q;
        alu_y = mc_q;
        // a zero multiplier bit still routes acc through the ALU unchanged
        ctl   = mp_q[0] ? CtlAdd : CtlPass;
      end
      DBL: begin
        alu_x = mc_q;
        alu_y = mc_q;
        ctl   = CtlAdd;
      end
      default: begin
        alu_x = 16'h0000;
        alu_y = 16'h0000;
        ctl   = CtlZero;
      end
    endcase
  end

  // State sequencing and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= 16'h0000;
      mc_q      <= 16'h0000;
      mp_q      <= 16'h0000;
      product_q <= 16'h0000;
      zr_q      <= 1'b1;
      ng_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q   <= 16'h0000;
            mc_q    <= a;
            mp_q    <= b;
            state_q <= ADD;
          end
        end
        ADD: begin
          acc_q   <= alu_out;
          // stop once no higher multiplier bits remain
          state_q <= (mp_q[15:1] == 15'd0) ? DONE : DBL;
        end
        DBL: begin
          mc_q    <= alu_out;
          mp_q    <= {1'b0, mp_q[15:1]};
          state_q <= ADD;
        end
        DONE: begin
          product_q <= acc_q;
          zr_q      <= (acc_q == 16'h0000);
          ng_q      <= acc_q[15];
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
